// File: rtl/matrix_operand_loader.sv
// Byte-serial loader that assembles a 2x2 A/B operand pair for the matrix multiplier
// and holds it on a valid/ready output until the consumer takes it.
module matrix_operand_loader #(
    parameter int ELEM_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ELEM_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*ELEM_W-1:0]   A,
    output logic [4*ELEM_W-1:0]   B,
    output logic [3:0]            fill
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [3:0]          fill_q, fill_d;
    logic [4*ELEM_W-1:0] a_q, a_d;
    logic [4*ELEM_W-1:0] b_q, b_d;
    logic                accept;

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;
    assign A         = a_q;
    assign B         = b_q;
    assign fill      = fill_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fill_d  = fill_q;
        a_d     = a_q;
        b_d     = b_q;
        // clear wins over an accept or transfer in the same cycle; A/B keep stale data
        if (clear) begin
            state_d = LOAD_A;
            idx_d   = 2'd0;
            fill_d  = 4'd0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (accept) begin
                        for (int s = 0; s < 4; s++) begin
                            if (idx_q == 2'(s)) a_d[(3-s)*ELEM_W +: ELEM_W] = in_data;
                        end
                        fill_d = fill_q + 4'd1;
                        idx_d  = idx_q + 2'd1;
                        if (idx_q == 2'd3) state_d = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        for (int s = 0; s < 4; s++) begin
                            if (idx_q == 2'(s)) b_d[(3-s)*ELEM_W +: ELEM_W] = in_data;
                        end
                        fill_d = fill_q + 4'd1;
                        idx_d  = idx_q + 2'd1;
                        if (idx_q == 2'd3) state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = LOAD_A;
                        idx_d   = 2'd0;
                        fill_d  = 4'd0;
                    end
                end
                default: begin
                    state_d = LOAD_A;
                    idx_d   = 2'd0;
                    fill_d  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_A;
            idx_q   <= 2'd0;
            fill_q  <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Scoreboard bench for matrix_operand_loader: the driver records accepted elements,
// packs expected A/B pairs from stream order, and a negedge monitor compares them.
module tb_matrix_operand_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        inValid;
    logic        inReady;
    logic [7:0]  inData;
    logic        outValid;
    logic        outReady;
    logic [31:0] matA;
    logic [31:0] matB;
    logic [3:0]  fill;

    int total = 0;
    int bad   = 0;
    logic [63:0] sbQ[$];
    logic [7:0]  partial[$];
    bit          randReady = 1'b0;

    matrix_operand_loader #(.ELEM_W(8)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(inValid), .in_ready(inReady), .in_data(inData),
        .out_valid(outValid), .out_ready(outReady),
        .A(matA), .B(matB), .fill(fill)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each presented pair must match the oldest expected pair; it retires on transfer
    always @(negedge clk) begin
        if (!rst && outValid === 1'b1) begin
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpectedPair: got %0h expected none", {matA, matB});
            end else begin
                checkOutput("pairAB", {matA, matB}, sbQ[0]);
                if (outReady) void'(sbQ.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (randReady) outReady = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one element (after an optional random idle gap) until the loader takes it
    task automatic applyStimulus(input logic [7:0] d, input int gapMax);
        int  g;
        int  tries;
        bit  acc;
        g = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
        inValid = 1'b0;
        repeat (g) begin
            inData = 8'($urandom);
            tick();
        end
        inValid = 1'b1;
        inData  = d;
        acc     = 1'b0;
        tries   = 0;
        while (!acc && tries < 100) begin
            acc = inReady;
            tick();
            tries++;
        end
        inValid = 1'b0;
        if (!acc) begin
            checkOutput("acceptTimeout", 64'(tries), 64'd0);
        end else begin
            partial.push_back(d);
            if (partial.size() == 8) begin
                sbQ.push_back({partial[0], partial[1], partial[2], partial[3],
                               partial[4], partial[5], partial[6], partial[7]});
                partial.delete();
            end
        end
    endtask

    task automatic sendPair(input logic [7:0] base, input int gapMax);
        for (int j = 0; j < 8; j++) applyStimulus(base + 8'(j), gapMax);
    endtask

    logic [7:0] specials[3];
    logic [7:0] rv;

    initial begin
        specials[0] = 8'h80;
        specials[1] = 8'hFF;
        specials[2] = 8'h00;
        rst = 1'b1; clear = 1'b0; inValid = 1'b0; inData = 8'h00; outReady = 1'b0;
        #23;
        checkOutput("rstInReady", 64'(inReady), 64'd1);
        checkOutput("rstOutValid", 64'(outValid), 64'd0);
        checkOutput("rstA", 64'(matA), 64'd0);
        checkOutput("rstB", 64'(matB), 64'd0);
        checkOutput("rstFill", 64'(fill), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();

        // First pair with consumer stalled; pair presented right after 8th accept
        sendPair(8'h01, 0);
        checkOutput("firstOutValid", 64'(outValid), 64'd1);
        checkOutput("firstA", 64'(matA), 64'h01020304);
        checkOutput("firstB", 64'(matB), 64'h05060708);
        checkOutput("firstFill", 64'(fill), 64'd8);

        // Upstream keeps pushing 0xFF while the pair is held
        inValid = 1'b1;
        inData  = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("holdInReady", 64'(inReady), 64'd0);
            checkOutput("holdA", 64'(matA), 64'h01020304);
            checkOutput("holdB", 64'(matB), 64'h05060708);
            checkOutput("holdFill", 64'(fill), 64'd8);
        end
        outReady = 1'b1;
        tick();
        inValid = 1'b0;
        checkOutput("xferOutValid", 64'(outValid), 64'd0);
        checkOutput("xferInReady", 64'(inReady), 64'd1);
        checkOutput("xferFill", 64'(fill), 64'd0);

        // Clear collides with the 4th element, which must be dropped
        applyStimulus(8'hAA, 0);
        applyStimulus(8'hBB, 0);
        applyStimulus(8'hCC, 0);
        checkOutput("partialFill", 64'(fill), 64'd3);
        inValid = 1'b1;
        inData  = 8'hDD;
        clear   = 1'b1;
        tick();
        clear   = 1'b0;
        inValid = 1'b0;
        partial.delete();
        checkOutput("clearFill", 64'(fill), 64'd0);
        checkOutput("clearInReady", 64'(inReady), 64'd1);
        sendPair(8'h11, 0);
        tick();

        // Back-to-back pairs with random input gaps
        sendPair(8'h01, 3);
        sendPair(8'h21, 3);

        // 0x80/0xFF/0x00 rotated through every slot
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 8; j++) applyStimulus(specials[(j + k) % 3], 0);

        // Random data with random gaps and random consumer back-pressure
        randReady = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 8; j++) begin
                case ($urandom_range(0, 3))
                    0: rv = 8'h00;
                    1: rv = 8'h80;
                    2: rv = 8'hFF;
                    default: rv = 8'($urandom);
                endcase
                applyStimulus(rv, 2);
            end
        end
        randReady = 1'b0;
        outReady  = 1'b1;
        tick();
        tick();

        // Asynchronous reset in the middle of loading B
        for (int j = 0; j < 6; j++) applyStimulus(8'h40 + 8'(j), 0);
        checkOutput("preRstFill", 64'(fill), 64'd6);
        #2 rst = 1'b1;
        #1;
        partial.delete();
        checkOutput("asyncRstOutValid", 64'(outValid), 64'd0);
        checkOutput("asyncRstInReady", 64'(inReady), 64'd1);
        checkOutput("asyncRstA", 64'(matA), 64'd0);
        checkOutput("asyncRstB", 64'(matB), 64'd0);
        checkOutput("asyncRstFill", 64'(fill), 64'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        sendPair(8'h31, 1);

        for (int w = 0; w < 50 && sbQ.size() != 0; w++) tick();
        checkOutput("sbDrained", 64'(sbQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
